// File: rtl/algo_3ror1w_rdrsp_collect.sv
// rtl/algo_3ror1w_rdrsp_collect.sv - read-response collector for the 3R/1W memory top
// Matches responses to issue tags, buffers them per port, gathers ECC statistics.
module algo_3ror1w_rdrsp_collect #(
    parameter int WIDTH      = 32,
    parameter int BITADDR    = 13,
    parameter int BITPADR    = 17,
    parameter int READ_DELAY = 4,
    parameter int TAGW       = 4,
    parameter int FIFODEPTH  = 8,
    parameter int BITFIFO    = 3,
    parameter int ERRCNTW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             read,
    input  logic [3*BITADDR-1:0]   rd_adr,
    input  logic [3*TAGW-1:0]      rd_tag,
    output logic [2:0]             rd_cred,
    input  logic [2:0]             rd_vld,
    input  logic [3*WIDTH-1:0]     rd_dout,
    input  logic [2:0]             rd_serr,
    input  logic [2:0]             rd_derr,
    input  logic [3*BITPADR-1:0]   rd_padr,
    output logic [2:0]             rsp_vld,
    input  logic [2:0]             rsp_rdy,
    output logic [3*WIDTH-1:0]     rsp_dout,
    output logic [3*TAGW-1:0]      rsp_tag,
    output logic [3*BITADDR-1:0]   rsp_adr,
    output logic [2:0]             rsp_serr,
    output logic [2:0]             rsp_derr,
    output logic [ERRCNTW-1:0]     serr_cnt,
    output logic [ERRCNTW-1:0]     derr_cnt,
    output logic                   err_vld,
    output logic [BITPADR-1:0]     err_padr,
    output logic                   seq_err,
    output logic                   ovf_err,
    input  logic                   err_clr
);
    localparam int ENTW = WIDTH + TAGW + BITADDR + 2;
    localparam int CNTW = BITFIFO + 1;

    logic [2:0][READ_DELAY-1:0]              pv_q, pv_d;
    logic [2:0][READ_DELAY-1:0][TAGW-1:0]    pt_q, pt_d;
    logic [2:0][READ_DELAY-1:0][BITADDR-1:0] pa_q, pa_d;
    logic [2:0][FIFODEPTH-1:0][ENTW-1:0]     mem_q, mem_d;
    logic [2:0][BITFIFO-1:0]                 wp_q, wp_d, rp_q, rp_d;
    logic [2:0][CNTW-1:0]                    cnt_q, cnt_d;
    logic [ERRCNTW-1:0]                      serr_cnt_q, serr_cnt_d, derr_cnt_q, derr_cnt_d;
    logic                                    err_vld_q, err_vld_d, seq_err_q, seq_err_d, ovf_err_q, ovf_err_d;
    logic [BITPADR-1:0]                      err_padr_q, err_padr_d;

    // Credits count reads still in the pipeline so a full FIFO can never be overrun.
    always_comb begin
        int infl;
        rd_cred = '0;
        for (int p = 0; p < 3; p++) begin
            infl = 0;
            for (int s = 0; s < READ_DELAY; s++) infl = infl + int'(pv_q[p][s]);
            rd_cred[p] = rst && ((int'(cnt_q[p]) + infl) < FIFODEPTH);
        end
    end

    always_comb begin
        logic            exp_v, pop, full, push_ok;
        logic [ENTW-1:0] entry;
        logic [1:0]      ns, nd;
        logic [ERRCNTW:0] ssum, dsum;
        pv_d = pv_q; pt_d = pt_q; pa_d = pa_q; mem_d = mem_q;
        wp_d = wp_q; rp_d = rp_q; cnt_d = cnt_q;
        ns = '0; nd = '0;
        err_vld_d  = err_clr ? 1'b0 : err_vld_q;
        err_padr_d = err_clr ? '0 : err_padr_q;
        seq_err_d  = err_clr ? 1'b0 : seq_err_q;
        ovf_err_d  = err_clr ? 1'b0 : ovf_err_q;
        for (int p = 0; p < 3; p++) begin
            exp_v = pv_q[p][READ_DELAY-1];
            entry = rd_vld[p] ? {rd_dout[p*WIDTH +: WIDTH], pt_q[p][READ_DELAY-1],
                                 pa_q[p][READ_DELAY-1], rd_serr[p], rd_derr[p]}
                              : {{WIDTH{1'b0}}, pt_q[p][READ_DELAY-1],
                                 pa_q[p][READ_DELAY-1], 1'b0, 1'b1};
            pop     = (cnt_q[p] != '0) && rsp_rdy[p];
            full    = cnt_q[p] == CNTW'(FIFODEPTH);
            push_ok = exp_v && !(full && !pop);
            pv_d[p][0] = read[p];
            pt_d[p][0] = rd_tag[p*TAGW +: TAGW];
            pa_d[p][0] = rd_adr[p*BITADDR +: BITADDR];
            for (int s = 1; s < READ_DELAY; s++) begin
                pv_d[p][s] = pv_q[p][s-1];
                pt_d[p][s] = pt_q[p][s-1];
                pa_d[p][s] = pa_q[p][s-1];
            end
            if (exp_v != rd_vld[p]) seq_err_d = 1'b1;
            if ((read[p] && !rd_cred[p]) || (exp_v && full && !pop)) ovf_err_d = 1'b1;
            if (pop) rp_d[p] = rp_q[p] + BITFIFO'(1);
            if (push_ok) begin
                mem_d[p][wp_q[p]] = entry;
                wp_d[p] = wp_q[p] + BITFIFO'(1);
            end
            cnt_d[p] = cnt_q[p] + CNTW'(push_ok) - CNTW'(pop);
            // Ascending port order makes the lowest derr port win the capture.
            if (exp_v && rd_vld[p]) begin
                if (rd_derr[p]) begin
                    nd = nd + 2'd1;
                    if (!err_vld_d) begin
                        err_vld_d  = 1'b1;
                        err_padr_d = rd_padr[p*BITPADR +: BITPADR];
                    end
                end else if (rd_serr[p]) begin
                    ns = ns + 2'd1;
                end
            end
        end
        ssum = {1'b0, (err_clr ? {ERRCNTW{1'b0}} : serr_cnt_q)} + {{(ERRCNTW-1){1'b0}}, ns};
        dsum = {1'b0, (err_clr ? {ERRCNTW{1'b0}} : derr_cnt_q)} + {{(ERRCNTW-1){1'b0}}, nd};
        serr_cnt_d = ssum[ERRCNTW] ? {ERRCNTW{1'b1}} : ssum[ERRCNTW-1:0];
        derr_cnt_d = dsum[ERRCNTW] ? {ERRCNTW{1'b1}} : dsum[ERRCNTW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pv_q <= '0; pt_q <= '0; pa_q <= '0;
            wp_q <= '0; rp_q <= '0; cnt_q <= '0;
            serr_cnt_q <= '0; derr_cnt_q <= '0;
            err_vld_q <= 1'b0; err_padr_q <= '0;
            seq_err_q <= 1'b0; ovf_err_q <= 1'b0;
        end else begin
            pv_q <= pv_d; pt_q <= pt_d; pa_q <= pa_d;
            wp_q <= wp_d; rp_q <= rp_d; cnt_q <= cnt_d;
            serr_cnt_q <= serr_cnt_d; derr_cnt_q <= derr_cnt_d;
            err_vld_q <= err_vld_d; err_padr_q <= err_padr_d;
            seq_err_q <= seq_err_d; ovf_err_q <= ovf_err_d;
        end
    end

    // Storage needs no reset; the head is masked by the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        logic [ENTW-1:0] head;
        rsp_vld = '0; rsp_dout = '0; rsp_tag = '0; rsp_adr = '0; rsp_serr = '0; rsp_derr = '0;
        for (int p = 0; p < 3; p++) begin
            rsp_vld[p] = cnt_q[p] != '0;
            head = rsp_vld[p] ? mem_q[p][rp_q[p]] : '0;
            rsp_derr[p] = head[0];
            rsp_serr[p] = head[1];
            rsp_adr[p*BITADDR +: BITADDR] = head[2 +: BITADDR];
            rsp_tag[p*TAGW +: TAGW]       = head[2+BITADDR +: TAGW];
            rsp_dout[p*WIDTH +: WIDTH]    = head[2+BITADDR+TAGW +: WIDTH];
        end
    end

    assign serr_cnt = serr_cnt_q;
    assign derr_cnt = derr_cnt_q;
    assign err_vld  = err_vld_q;
    assign err_padr = err_padr_q;
    assign seq_err  = seq_err_q;
    assign ovf_err  = ovf_err_q;
endmodule

// File: tb/tb_algo_3ror1w_rdrsp_collect.sv
// tb/tb_algo_3ror1w_rdrsp_collect.sv - randomized bench for algo_3ror1w_rdrsp_collect
// Queue-based reference model: pending issues with due cycles, response FIFOs as queues.
module tb_algo_3ror1w_rdrsp_collect;
    localparam int W = 32, A = 13, PA = 17, RD = 4, T = 4, D = 8, CW = 16;

    logic          clk = 1'b0, rst = 1'b0, err_clr = 1'b0;
    logic [2:0]    read = '0, rd_vld = '0, rd_serr = '0, rd_derr = '0, rsp_rdy = '0;
    logic [3*A-1:0]  rd_adr = '0;
    logic [3*T-1:0]  rd_tag = '0;
    logic [3*W-1:0]  rd_dout = '0;
    logic [3*PA-1:0] rd_padr = '0;
    logic [2:0]    rd_cred, rsp_vld, rsp_serr, rsp_derr;
    logic [3*W-1:0]  rsp_dout;
    logic [3*T-1:0]  rsp_tag;
    logic [3*A-1:0]  rsp_adr;
    logic [CW-1:0] serr_cnt, derr_cnt;
    logic          err_vld, seq_err, ovf_err;
    logic [PA-1:0] err_padr;

    algo_3ror1w_rdrsp_collect #(.WIDTH(W), .BITADDR(A), .BITPADR(PA), .READ_DELAY(RD),
        .TAGW(T), .FIFODEPTH(D), .BITFIFO(3), .ERRCNTW(CW)) dut (
        .clk(clk), .rst(rst), .read(read), .rd_adr(rd_adr), .rd_tag(rd_tag), .rd_cred(rd_cred),
        .rd_vld(rd_vld), .rd_dout(rd_dout), .rd_serr(rd_serr), .rd_derr(rd_derr), .rd_padr(rd_padr),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dout(rsp_dout), .rsp_tag(rsp_tag),
        .rsp_adr(rsp_adr), .rsp_serr(rsp_serr), .rsp_derr(rsp_derr), .serr_cnt(serr_cnt),
        .derr_cnt(derr_cnt), .err_vld(err_vld), .err_padr(err_padr), .seq_err(seq_err),
        .ovf_err(ovf_err), .err_clr(err_clr));

    always #5 clk = ~clk;

    typedef struct { logic [T-1:0] tag; logic [A-1:0] adr; int due; } iss_t;
    typedef struct { logic [W-1:0] d; logic [T-1:0] tag; logic [A-1:0] adr; logic s; logic e; } ent_t;

    iss_t pend[3][$];
    ent_t fq[3][$];
    int   cyc = 0, m_serr = 0, m_derr = 0;
    bit   m_evld = 0, m_seq = 0, m_ovf = 0;
    logic [PA-1:0] m_epadr = '0;
    int   n_pass = 0, n_chk = 0;
    logic [2:0] rq[$];
    logic [2:0] kill = '0, force_v = '0;

    function automatic bit mcred(int p);
        return rst && ((fq[p].size() + pend[p].size()) < D);
    endfunction

    always @(posedge clk) begin
        int ns, nd, bs, bd;
        if (!rst) begin
            for (int p = 0; p < 3; p++) begin pend[p].delete(); fq[p].delete(); end
            m_serr = 0; m_derr = 0; m_evld = 0; m_seq = 0; m_ovf = 0; m_epadr = '0;
        end else begin
            ns = 0; nd = 0;
            if (err_clr) begin m_evld = 0; m_epadr = '0; m_seq = 0; m_ovf = 0; end
            for (int p = 0; p < 3; p++) begin
                bit ex, pop;
                ent_t e;
                iss_t hd;
                ex  = pend[p].size() > 0 && pend[p][0].due == cyc;
                pop = fq[p].size() > 0 && rsp_rdy[p];
                if (read[p] && !mcred(p)) m_ovf = 1;
                if (ex != rd_vld[p]) m_seq = 1;
                if (pop) void'(fq[p].pop_front());
                if (ex) begin
                    hd = pend[p].pop_front();
                    e.tag = hd.tag; e.adr = hd.adr;
                    if (rd_vld[p]) begin
                        e.d = rd_dout[p*W +: W]; e.s = rd_serr[p]; e.e = rd_derr[p];
                        if (rd_derr[p]) begin
                            nd++;
                            if (!m_evld) begin m_evld = 1; m_epadr = rd_padr[p*PA +: PA]; end
                        end else if (rd_serr[p]) ns++;
                    end else begin
                        e.d = '0; e.s = 0; e.e = 1;
                    end
                    if (fq[p].size() >= D) m_ovf = 1;
                    else fq[p].push_back(e);
                end
                if (read[p]) pend[p].push_back('{rd_tag[p*T +: T], rd_adr[p*A +: A], cyc + RD});
            end
            bs = (err_clr ? 0 : m_serr) + ns;
            bd = (err_clr ? 0 : m_derr) + nd;
            m_serr = (bs > 65535) ? 65535 : bs;
            m_derr = (bd > 65535) ? 65535 : bd;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic check_all();
        for (int p = 0; p < 3; p++) begin
            chk("rd_cred", 64'(rd_cred[p]), 64'(mcred(p)));
            chk("rsp_vld", 64'(rsp_vld[p]), 64'(fq[p].size() > 0));
            if (fq[p].size() > 0) begin
                chk("rsp_dout", 64'(rsp_dout[p*W +: W]), 64'(fq[p][0].d));
                chk("rsp_tag", 64'(rsp_tag[p*T +: T]), 64'(fq[p][0].tag));
                chk("rsp_adr", 64'(rsp_adr[p*A +: A]), 64'(fq[p][0].adr));
                chk("rsp_flags", 64'({rsp_serr[p], rsp_derr[p]}), 64'({fq[p][0].s, fq[p][0].e}));
            end else begin
                chk("rsp_idle", 64'({rsp_dout[p*W +: W], rsp_serr[p], rsp_derr[p]}), 64'(0));
            end
        end
        chk("serr_cnt", 64'(serr_cnt), 64'(m_serr));
        chk("derr_cnt", 64'(derr_cnt), 64'(m_derr));
        chk("err_vld", 64'(err_vld), 64'(m_evld));
        if (m_evld) chk("err_padr", 64'(err_padr), 64'(m_epadr));
        chk("seq_err", 64'(seq_err), 64'(m_seq));
        chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    endtask

    task automatic tick();
        logic [2:0] a;
        rq.push_back(read);
        if (rq.size() > RD + 1) void'(rq.pop_front());
        a = (rq.size() == RD + 1) ? rq[0] : 3'b000;
        rd_vld = (a & ~kill) | force_v;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        read = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rnd_data();
        rd_dout = {$urandom, $urandom, $urandom};
        rd_padr = {$urandom, $urandom};
        rd_adr  = {$urandom, $urandom};
        rd_tag  = 12'($urandom);
    endtask

    initial begin
        int guard;
        rst = 1'b0;
        idle(3);
        chk("reset_cred", 64'(rd_cred), 64'(0));
        rst = 1'b1;
        idle(1);
        chk("cred_after_reset", 64'(rd_cred), 64'(3'b111));

        // single read on port 0
        read = 3'b001; rd_adr[0 +: A] = 13'h0A5; rd_tag[0 +: T] = 4'd3; tick();
        idle(3);
        rd_dout[0 +: W] = 32'hDEADBEEF; tick();
        chk("t1_vld", 64'(rsp_vld[0]), 64'(1));
        chk("t1_dout", 64'(rsp_dout[0 +: W]), 64'(32'hDEADBEEF));
        chk("t1_tag", 64'(rsp_tag[0 +: T]), 64'(3));
        chk("t1_adr", 64'(rsp_adr[0 +: A]), 64'(13'h0A5));
        rsp_rdy = 3'b001; tick(); rsp_rdy = '0;
        chk("t1_popped", 64'(rsp_vld[0]), 64'(0));

        // fill port 1 with the consumer stalled
        for (int i = 0; i < 8; i++) begin rnd_data(); read = 3'b010; tick(); end
        chk("t2_cred_low", 64'(rd_cred[1]), 64'(0));
        rnd_data(); read = 3'b010; tick();
        chk("t2_ovf", 64'(ovf_err), 64'(1));
        idle(6);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        rsp_rdy = 3'b010; tick(); rsp_rdy = '0;
        read = 3'b010; rnd_data(); tick();
        read = 3'b010; rnd_data(); tick();
        read = '0; err_clr = 1'b1; tick(); err_clr = 1'b0;
        idle(2);
        rsp_rdy = 3'b010; tick(); rsp_rdy = '0;
        chk("t6_no_ovf", 64'(ovf_err), 64'(0));
        chk("t6_full", 64'(rsp_vld[1]), 64'(1));
        rsp_rdy = 3'b111; idle(10); rsp_rdy = '0;

        // simultaneous errors on all ports
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        read = 3'b111; tick(); idle(3);
        rd_serr = 3'b001; rd_derr = 3'b110;
        rd_padr = {17'h0777, 17'h1234, 17'h0};
        tick();
        rd_serr = '0; rd_derr = '0;
        chk("t3_serr", 64'(serr_cnt), 64'(1));
        chk("t3_derr", 64'(derr_cnt), 64'(2));
        chk("t3_padr", 64'(err_padr), 64'(17'h1234));
        chk("t3_evld", 64'(err_vld), 64'(1));
        rsp_rdy = 3'b111; idle(3);

        // derr counter saturation
        guard = 0;
        rd_derr = 3'b111;
        while (m_derr != 65535 && guard < 30000) begin
            rnd_data(); rd_serr = 3'($urandom); read = 3'b111; tick(); guard++;
        end
        idle(6);
        rd_derr = '0; rd_serr = '0;
        chk("t4_sat", 64'(derr_cnt), 64'(16'hFFFF));
        read = 3'b001; tick(); idle(3);
        err_clr = 1'b1; rd_serr = 3'b001; tick();
        err_clr = 1'b0; rd_serr = '0;
        chk("t4_clr_serr", 64'(serr_cnt), 64'(1));
        chk("t4_clr_derr", 64'(derr_cnt), 64'(0));
        chk("t4_clr_evld", 64'(err_vld), 64'(0));

        // missing and spurious responses
        rsp_rdy = '0;
        read = 3'b100; rnd_data(); tick(); idle(3);
        kill = 3'b100; tick(); kill = '0;
        chk("t5_miss_derr", 64'(rsp_derr[2]), 64'(1));
        chk("t5_miss_dout", 64'(rsp_dout[2*W +: W]), 64'(0));
        chk("t5_seq", 64'(seq_err), 64'(1));
        chk("t5_cnt", 64'(derr_cnt), 64'(0));
        rsp_rdy = 3'b111; err_clr = 1'b1; tick(); err_clr = 1'b0;
        force_v = 3'b010; tick(); force_v = '0;
        chk("t5_spur_vld", 64'(rsp_vld[1]), 64'(0));
        chk("t5_spur_seq", 64'(seq_err), 64'(1));

        // randomized traffic with a reset in the middle
        for (int c = 0; c < 3000; c++) begin
            rnd_data();
            for (int p = 0; p < 3; p++)
                read[p] = ($urandom_range(3) != 0) && (mcred(p) || $urandom_range(30) == 0);
            rsp_rdy = 3'($urandom);
            rd_serr = 3'($urandom); rd_derr = 3'($urandom) & 3'($urandom);
            err_clr = $urandom_range(60) == 0;
            kill    = ($urandom_range(40) == 0) ? 3'($urandom) : 3'b000;
            force_v = ($urandom_range(40) == 0) ? 3'($urandom) : 3'b000;
            rst = !(c >= 1500 && c < 1503);
            tick();
            if (!rst) begin
                chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
                chk("rst_cred", 64'(rd_cred), 64'(0));
            end
            if (c == 1503) chk("rst_cred_back", 64'(rd_cred), 64'(3'b111));
        end
        kill = '0; force_v = '0; err_clr = 1'b0; rsp_rdy = 3'b111;
        idle(12);
        chk("final_cred", 64'(rd_cred), 64'(3'b111));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
